fifo_wr_arbiter: RTL and testbench

Write-side arbiter and sequencer for the asynchronous FIFO's write port. It shares the single FIFO write interface (we/datain/full) among NREQ requesters using round-robin, burst-limited grants. It lives entirely in the FIFO write-clock domain and drives the FIFO's we and datain from registers.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, XFER} arb_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_DATA  = 8;
  localparam int DEF_BURST = 4;
  localparam int OWNER_W   = 3;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic               valid,
  output logic [OWNER_W-1:0] idx,
  output logic [NREQ-1:0]    onehot
);

  int d;
  int best;

  // Distance from last_owner+1 (mod NREQ); the closest requester wins.
  always_comb begin
    best = NREQ;
    d    = 0;
    idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + 2*NREQ - int'(last_owner) - 1) % NREQ;
      if (req[i] && d < best) begin
        best = d;
        idx  = OWNER_W'(i);
      end
    end
    valid  = |req;
    onehot = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO write port among NREQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int DATA  = DEF_DATA,
  parameter int BURST = DEF_BURST
) (
  input  logic                 wclk,
  input  logic                 wreset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DATA-1:0] req_data,
  output logic [NREQ-1:0]      gnt,
  input  logic                 fifo_full,
  output logic                 fifo_we,
  output logic [DATA-1:0]      fifo_datain,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic [CNT_W-1:0]     beat_cnt
);

  arb_state_t         state;
  logic [OWNER_W-1:0] last_owner;
  logic               pick_vld;
  logic [OWNER_W-1:0] pick_idx;
  logic [NREQ-1:0]    pick_oh;
  logic               owner_req;
  logic               accept;
  logic               last_beat;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [DATA-1:0]    sel_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .valid      (pick_vld),
    .idx        (pick_idx),
    .onehot     (pick_oh)
  );

  // gnt is one-hot and stable through XFER, so it doubles as the owner decode.
  assign owner_req = |(req & gnt);
  assign accept    = (state == XFER) && owner_req && !fifo_full;
  assign cnt_nxt   = beat_cnt + CNT_W'(1);
  assign last_beat = (cnt_nxt == CNT_W'(BURST));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) sel_data = req_data[i*DATA +: DATA];
  end

  always_ff @(posedge wclk) begin
    if (!wreset) begin
      state       <= IDLE;
      gnt         <= '0;
      fifo_we     <= 1'b0;
      fifo_datain <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      last_owner  <= OWNER_W'(NREQ-1);
    end else begin
      fifo_we <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld && !fifo_full) begin
            gnt      <= pick_oh;
            owner    <= pick_idx;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            fifo_we     <= 1'b1;
            fifo_datain <= sel_data;
            beat_cnt    <= cnt_nxt;
          end
          // A dropped request releases even while stalled on full.
          if ((accept && last_beat) || !owner_req) begin
            state      <= IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            last_owner <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: requester queues drive req; scoreboard checks each FIFO write.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DATA  = 8;
  localparam int BURST = 4;

  typedef struct {
    logic [2:0] own;
    logic [7:0] data;
  } wr_t;

  logic                 wclk = 1'b0;
  logic                 wreset;
  logic [NREQ-1:0]      req;
  logic [NREQ*DATA-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic                 fifo_full;
  logic                 fifo_we;
  logic [DATA-1:0]      fifo_datain;
  logic [2:0]           owner;
  logic                 busy;
  logic [3:0]           beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  wr_t        exp_q[$];
  logic [7:0] mem[NREQ][16];
  int         wp[NREQ];
  int         rp[NREQ];
  logic [NREQ-1:0] acc;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA(DATA), .BURST(BURST)) dut (
    .wclk        (wclk),
    .wreset      (wreset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .fifo_full   (fifo_full),
    .fifo_we     (fifo_we),
    .fifo_datain (fifo_datain),
    .owner       (owner),
    .busy        (busy),
    .beat_cnt    (beat_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic load(input int i, input logic [7:0] d);
    mem[i][wp[i]] = d;
    wp[i]++;
  endtask

  task automatic expect_wr(input logic [2:0] o, input logic [7:0] d);
    wr_t w;
    w.own  = o;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // One cycle of requester behaviour, acting at the negedge.
  task automatic step(input logic full);
    @(negedge wclk);
    for (int i = 0; i < NREQ; i++) if (acc[i]) rp[i]++;
    fifo_full = full;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rp[i] < wp[i]);
      req_data[i*DATA +: DATA] = req[i] ? mem[i][rp[i]] : 8'h00;
    end
    acc = req & gnt & {NREQ{~full & wreset}};
  endtask

  task automatic clear_q();
    for (int i = 0; i < NREQ; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    acc = '0;
  endtask

  task automatic do_reset();
    wreset = 1'b0;
    clear_q();
    step(1'b0);
    step(1'b0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_we", 32'(fifo_we), 32'h0);
    chk("rst_datain", 32'(fifo_datain), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_beat", 32'(beat_cnt), 32'h0);
    wreset = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      done = (busy === 1'b0) && (exp_q.size() == 0);
      for (int i = 0; i < NREQ; i++) if (rp[i] < wp[i]) done = 0;
      if (!done) step(1'b0);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_drain: %0d writes still expected, busy=%b", name, exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected entry.
  initial begin
    wr_t w;
    forever begin
      @(posedge wclk);
      #1;
      if (fifo_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got data %0h owner %0d, expected none", fifo_datain, owner);
        end else begin
          w = exp_q.pop_front();
          if (fifo_datain !== w.data || owner !== w.own) begin
            n_bad++;
            $display("FAIL write: got data %0h owner %0d expected data %0h owner %0d",
                     fifo_datain, owner, w.data, w.own);
          end
        end
      end
    end
  end

  initial begin
    wreset = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0; acc = '0;
    for (int i = 0; i < NREQ; i++) begin wp[i] = 0; rp[i] = 0; end

    // Single requester, 6 beats split into bursts of 4 and 2
    do_reset();
    for (int k = 0; k < 6; k++) begin load(0, 8'h10 + 8'(k)); expect_wr(3'd0, 8'h10 + 8'(k)); end
    step(1'b0);
    step(1'b0); chk("t1_gnt_first", 32'(gnt), 32'h1);
    chk("t1_beat0", 32'(beat_cnt), 32'h0);
    repeat (4) step(1'b0);
    chk("t1_bubble_gnt", 32'(gnt), 32'h0);
    chk("t1_bubble_busy", 32'(busy), 32'h0);
    chk("t1_bubble_beat", 32'(beat_cnt), 32'h0);
    step(1'b0); chk("t1_regrant", 32'(gnt), 32'h1);
    repeat (2) step(1'b0);
    chk("t1_beat2", 32'(beat_cnt), 32'h2);
    step(1'b0);
    chk("t1_release_gnt", 32'(gnt), 32'h0);
    chk("t1_hold_datain", 32'(fifo_datain), 32'h15);
    chk("t1_we_low", 32'(fifo_we), 32'h0);
    drain("t1");

    // All four requesting: order 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 5; k++) load(0, 8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) begin
      load(1, 8'h30 + 8'(k)); load(2, 8'h40 + 8'(k)); load(3, 8'h50 + 8'(k));
    end
    for (int k = 0; k < 4; k++) expect_wr(3'd0, 8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) expect_wr(3'd1, 8'h30 + 8'(k));
    for (int k = 0; k < 4; k++) expect_wr(3'd2, 8'h40 + 8'(k));
    for (int k = 0; k < 4; k++) expect_wr(3'd3, 8'h50 + 8'(k));
    expect_wr(3'd0, 8'h24);
    step(1'b0);
    step(1'b0); chk("t2_gnt0", 32'(gnt), 32'h1);
    repeat (4) step(1'b0); chk("t2_bubble", 32'(gnt), 32'h0);
    step(1'b0); chk("t2_gnt1", 32'(gnt), 32'h2);
    chk("t2_owner1", 32'(owner), 32'h1);
    drain("t2");

    // Full stall after the 2nd beat of requester 1
    do_reset();
    for (int k = 0; k < 4; k++) begin load(1, 8'h60 + 8'(k)); expect_wr(3'd1, 8'h60 + 8'(k)); end
    step(1'b0);
    step(1'b0); chk("t3_gnt", 32'(gnt), 32'h2);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    chk("t3_stall_we_a", 32'(fifo_we), 32'h0);
    chk("t3_stall_beat_a", 32'(beat_cnt), 32'h2);
    chk("t3_stall_gnt_a", 32'(gnt), 32'h2);
    step(1'b1);
    chk("t3_stall_we_b", 32'(fifo_we), 32'h0);
    chk("t3_stall_beat_b", 32'(beat_cnt), 32'h2);
    step(1'b0);
    chk("t3_stall_we_c", 32'(fifo_we), 32'h0);
    chk("t3_stall_busy_c", 32'(busy), 32'h1);
    step(1'b0); chk("t3_beat3", 32'(beat_cnt), 32'h3);
    step(1'b0);
    chk("t3_release_gnt", 32'(gnt), 32'h0);
    chk("t3_release_beat", 32'(beat_cnt), 32'h0);
    chk("t3_last_we", 32'(fifo_we), 32'h1);
    drain("t3");

    // Requester 2 drops after one beat; requester 3 is next, ahead of 0
    do_reset();
    load(2, 8'h70); load(3, 8'h80); load(3, 8'h81);
    expect_wr(3'd2, 8'h70); expect_wr(3'd3, 8'h80); expect_wr(3'd3, 8'h81); expect_wr(3'd0, 8'h90);
    step(1'b0);
    step(1'b0); chk("t4_gnt2", 32'(gnt), 32'h4);
    step(1'b0);
    chk("t4_beat1", 32'(beat_cnt), 32'h1);
    chk("t4_busy", 32'(busy), 32'h1);
    load(0, 8'h90);
    step(1'b0); chk("t4_release", 32'(gnt), 32'h0);
    step(1'b0); chk("t4_gnt3", 32'(gnt), 32'h8);
    drain("t4");

    // Reset mid-burst of requester 1
    do_reset();
    for (int k = 0; k < 4; k++) load(1, 8'hA0 + 8'(k));
    expect_wr(3'd1, 8'hA0);
    step(1'b0);
    step(1'b0); chk("t5_gnt1", 32'(gnt), 32'h2);
    step(1'b0);
    wreset = 1'b0;
    acc = '0;
    step(1'b0);
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_we", 32'(fifo_we), 32'h0);
    chk("t5_rst_datain", 32'(fifo_datain), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    clear_q();
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'hB0 + 8'(i));
      expect_wr(3'(i), 8'hB0 + 8'(i));
    end
    step(1'b0);
    wreset = 1'b1;
    step(1'b0); chk("t5_first_gnt", 32'(gnt), 32'h1);
    drain("t5");

    // Full in IDLE blocks a grant
    do_reset();
    load(2, 8'hC0); expect_wr(3'd2, 8'hC0);
    step(1'b1);
    step(1'b1); chk("t6_blocked_a", 32'(gnt), 32'h0);
    step(1'b0); chk("t6_blocked_b", 32'(gnt), 32'h0);
    step(1'b0); chk("t6_gnt2", 32'(gnt), 32'h4);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
